// File: rtl/ddram_arbiter_if.sv
// Signal bundle between the DDR3 port arbiter, its three toggle-handshake
// clients and the downstream ddram port.
interface ddram_arbiter_if;
  logic [23:0] ldr_addr;
  logic [15:0] ldr_din;
  logic        ldr_req;
  logic        ldr_ack;
  logic [19:0] rom_addr;
  logic        rom_req;
  logic        rom_ack;
  logic [63:0] rom_dout;
  logic        hdr_skip;
  logic [27:0] aux_addr;
  logic [15:0] aux_din;
  logic        aux_we;
  logic        aux_req;
  logic        aux_ack;
  logic [63:0] aux_dout;
  logic [27:0] dd_wraddr;
  logic [15:0] dd_din;
  logic        dd_we_req;
  logic        dd_we_ack;
  logic [27:0] dd_rdaddr;
  logic        dd_rd_req;
  logic        dd_rd_ack;
  logic [63:0] dd_dout;
  logic        busy;

  modport master (
    input  ldr_addr, ldr_din, ldr_req, rom_addr, rom_req, hdr_skip,
           aux_addr, aux_din, aux_we, aux_req, dd_we_ack, dd_rd_ack, dd_dout,
    output ldr_ack, rom_ack, rom_dout, aux_ack, aux_dout,
           dd_wraddr, dd_din, dd_we_req, dd_rdaddr, dd_rd_req, busy
  );

  modport slave (
    output ldr_addr, ldr_din, ldr_req, rom_addr, rom_req, hdr_skip,
           aux_addr, aux_din, aux_we, aux_req, dd_we_ack, dd_rd_ack, dd_dout,
    input  ldr_ack, rom_ack, rom_dout, aux_ack, aux_dout,
           dd_wraddr, dd_din, dd_we_req, dd_rdaddr, dd_rd_req, busy
  );
endinterface

// File: rtl/ddram_arbiter.sv
// Serialises ROM loader writes, ROM reads and aux reads/writes onto the single
// toggle-handshake ddram port, with a starvation guard for the aux client.
module ddram_arbiter #(
  parameter int unsigned STARVE_MAX = 8,
  parameter logic [27:0] AUX_BASE   = 28'h0800000
) (
  input logic             clk_sys,
  input logic             reset,
  ddram_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, WAIT_WR, WAIT_RD, DONE} state_t;
  typedef enum logic [1:0] {OWN_ROM, OWN_LDR, OWN_AUX} owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state_q, state_d;
  owner_t      owner_q, grant_owner;
  logic        grant, grant_wr;
  logic        ldr_ack_q, rom_ack_q, aux_ack_q;
  logic        we_req_q, rd_req_q;
  logic [27:0] wraddr_q, rdaddr_q;
  logic [15:0] din_q;
  logic [63:0] rom_dout_q, aux_dout_q;
  logic [3:0]  starve_cnt, starve_d;

  logic        ldr_pend, rom_pend, aux_pend, rd_done;
  logic [27:0] rom_byte, aux_byte;

  assign ldr_pend = bus.ldr_req != ldr_ack_q;
  assign rom_pend = bus.rom_req != rom_ack_q;
  assign aux_pend = bus.aux_req != aux_ack_q;
  assign rom_byte = {5'h0, bus.rom_addr, 3'b000} + (bus.hdr_skip ? 28'h200 : 28'h0);
  assign aux_byte = bus.aux_addr + AUX_BASE;
  assign rd_done  = (state_q == WAIT_RD) && (bus.dd_rd_ack == rd_req_q);

  // NOTE: every output of this block is given a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_cnt;
    grant       = 1'b0;
    grant_owner = OWN_ROM;
    grant_wr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (aux_pend && starve_cnt == STARVE_LIM) begin
          grant = 1'b1; grant_owner = OWN_AUX;
        end else if (rom_pend) begin
          grant = 1'b1; grant_owner = OWN_ROM;
        end else if (ldr_pend) begin
          grant = 1'b1; grant_owner = OWN_LDR;
        end else if (aux_pend) begin
          grant = 1'b1; grant_owner = OWN_AUX;
        end
        grant_wr = (grant_owner == OWN_LDR) || (grant_owner == OWN_AUX && bus.aux_we);
        if (grant) state_d = grant_wr ? WAIT_WR : WAIT_RD;
        // Aux losing to rom/ldr accumulates; any aux win or aux idle clears.
        if (!aux_pend || (grant && grant_owner == OWN_AUX))
          starve_d = 4'h0;
        else if (grant && starve_cnt != STARVE_LIM)
          starve_d = starve_cnt + 4'h1;
      end
      WAIT_WR: if (bus.dd_we_ack == we_req_q) state_d = DONE;
      WAIT_RD: if (bus.dd_rd_ack == rd_req_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_ROM;
      ldr_ack_q  <= 1'b0;
      rom_ack_q  <= 1'b0;
      aux_ack_q  <= 1'b0;
      we_req_q   <= 1'b0;
      rd_req_q   <= 1'b0;
      wraddr_q   <= '0;
      rdaddr_q   <= '0;
      din_q      <= '0;
      rom_dout_q <= '0;
      aux_dout_q <= '0;
      starve_cnt <= '0;
    end else begin
      state_q    <= state_d;
      starve_cnt <= starve_d;
      if (grant) begin
        owner_q <= grant_owner;
        case (grant_owner)
          OWN_ROM: begin
            rdaddr_q <= rom_byte;
            rd_req_q <= ~rd_req_q;
          end
          OWN_LDR: begin
            wraddr_q <= {4'h0, bus.ldr_addr};
            din_q    <= bus.ldr_din;
            we_req_q <= ~we_req_q;
          end
          default: begin
            if (bus.aux_we) begin
              wraddr_q <= aux_byte;
              din_q    <= bus.aux_din;
              we_req_q <= ~we_req_q;
            end else begin
              rdaddr_q <= aux_byte;
              rd_req_q <= ~rd_req_q;
            end
          end
        endcase
      end
      if (rd_done) begin
        if (owner_q == OWN_ROM) rom_dout_q <= bus.dd_dout;
        else if (owner_q == OWN_AUX) aux_dout_q <= bus.dd_dout;
      end
      if (state_q == DONE) begin
        case (owner_q)
          OWN_ROM: rom_ack_q <= ~rom_ack_q;
          OWN_LDR: ldr_ack_q <= ~ldr_ack_q;
          default: aux_ack_q <= ~aux_ack_q;
        endcase
      end
    end
  end

  assign bus.ldr_ack   = ldr_ack_q;
  assign bus.rom_ack   = rom_ack_q;
  assign bus.aux_ack   = aux_ack_q;
  assign bus.rom_dout  = rom_dout_q;
  assign bus.aux_dout  = aux_dout_q;
  assign bus.dd_wraddr = wraddr_q;
  assign bus.dd_din    = din_q;
  assign bus.dd_we_req = we_req_q;
  assign bus.dd_rdaddr = rdaddr_q;
  assign bus.dd_rd_req = rd_req_q;
  assign bus.busy      = state_q != IDLE;
endmodule
